// File: rtl/noc_traffic_injector.sv
// PE-side NoC traffic injector: single-flit header packets on a req/gnt Local port.
// Optional INJ_STATS_EN adds saturating sent_cnt/stall_cnt outputs.
module noc_traffic_injector #(
  parameter int unsigned          DATA_WIDTH  = 32,
  parameter int unsigned          DIM         = 4,
  parameter int unsigned          PKT_ID_W    = 10,
  parameter int unsigned          MOD_ID_W    = 6,
  parameter logic [MOD_ID_W-1:0]  MODULE_ID   = '0,
  parameter logic [DIM-1:0]       X_SRC       = '0,
  parameter logic [DIM-1:0]       Y_SRC       = '0,
  parameter int unsigned          GAP_W       = 4,
  parameter int unsigned          MAX_PACKETS = 1023,
  parameter logic [15:0]          LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [1:0]            mode,
  input  logic [DIM-1:0]        cfg_dst_x,
  input  logic [DIM-1:0]        cfg_dst_y,
  input  logic [GAP_W-1:0]      gap_cfg,
  input  logic                  gap_rand,
  output logic                  ReqDnStr,
  input  logic                  GntDnStr,
  input  logic                  DnStrFull,
  output logic [DATA_WIDTH-1:0] PacketOut,
`ifdef INJ_STATS_EN
  output logic [31:0]           sent_cnt,
  output logic [31:0]           stall_cnt,
`endif
  output logic                  done
);

  localparam int unsigned HDR_W = 4*DIM + PKT_ID_W + MOD_ID_W;

  typedef enum logic [2:0] {IDLE, GAP, SEND, WAIT, DONE} state_t;

  state_t                state_q, state_d;
  logic                  req_q, req_d;
  logic [DATA_WIDTH-1:0] pkt_q, pkt_d;
  logic [PKT_ID_W-1:0]   id_q, id_d, id_inc;
  logic [GAP_W-1:0]      cnt_q, cnt_d;
  logic [GAP_W-1:0]      delay_q, delay_d;
  logic [15:0]           lfsr_q, lfsr_d;
  logic [DIM-1:0]        dst_x, dst_y;
  logic [DATA_WIDTH-1:0] hdr;
  logic                  budget_hit;

  // Galois LFSR, mask 0xB400, free-running regardless of state
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]};
    if (lfsr_q[0]) lfsr_d = lfsr_d ^ 16'hB400;
  end

  always_comb begin
    dst_x = cfg_dst_x;
    dst_y = cfg_dst_y;
    unique case (mode)
      2'd0: begin
        dst_x = cfg_dst_x;
        dst_y = cfg_dst_y;
      end
      2'd1: begin
        dst_x = lfsr_q[2*DIM-1 -: DIM];
        dst_y = lfsr_q[DIM-1:0];
        // never address ourselves: flip the x LSB on a self-hit
        if (dst_x == X_SRC && dst_y == Y_SRC) dst_x[0] = ~dst_x[0];
      end
      2'd2: begin
        dst_x = Y_SRC;
        dst_y = X_SRC;
      end
      default: begin
        dst_x = ~X_SRC;
        dst_y = ~Y_SRC;
      end
    endcase
  end

  assign id_inc = id_q + 1'b1;

  always_comb begin
    hdr = '0;
    hdr[DATA_WIDTH-1 -: HDR_W] = {dst_x, dst_y, X_SRC, Y_SRC, id_inc, MODULE_ID};
  end

  assign budget_hit = (MAX_PACKETS != 0) && (32'(id_q) == MAX_PACKETS);

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    pkt_d   = pkt_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    delay_d = delay_q;
    unique case (state_q)
      IDLE: begin
        if (en) begin
          delay_d = gap_rand ? lfsr_q[GAP_W-1:0] : gap_cfg;
          cnt_d   = '0;
          state_d = GAP;
        end
      end
      GAP: begin
        if (!en)                   state_d = IDLE;
        else if (cnt_q == delay_q) state_d = SEND;
        else                       cnt_d   = cnt_q + 1'b1;
      end
      SEND: begin
        if (!DnStrFull) begin
          id_d    = id_inc;
          pkt_d   = hdr;
          req_d   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (GntDnStr) begin
          req_d   = 1'b0;
          state_d = budget_hit ? DONE : IDLE;
        end
      end
      DONE: req_d = 1'b0;
      default: begin
        req_d   = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      pkt_q   <= '0;
      id_q    <= '0;
      cnt_q   <= '0;
      delay_q <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      pkt_q   <= pkt_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      delay_q <= delay_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign ReqDnStr  = req_q;
  assign PacketOut = pkt_q;
  assign done      = (state_q == DONE);

`ifdef INJ_STATS_EN
  logic [31:0] sent_q, sent_d, stall_q, stall_d;

  always_comb begin
    sent_d  = sent_q;
    stall_d = stall_q;
    if (state_q == WAIT && GntDnStr && sent_q != '1) sent_d = sent_q + 1'b1;
    if (((state_q == SEND && DnStrFull) || (state_q == WAIT && !GntDnStr)) && stall_q != '1)
      stall_d = stall_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sent_q  <= '0;
      stall_q <= '0;
    end else begin
      sent_q  <= sent_d;
      stall_q <= stall_d;
    end
  end

  assign sent_cnt  = sent_q;
  assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_noc_traffic_injector.sv
// Scoreboard bench for noc_traffic_injector: directed timing cases plus randomized traffic.
module tb_noc_traffic_injector;

  localparam int unsigned MAXP = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [1:0]  mode = '0;
  logic [3:0]  cfg_dst_x = '0, cfg_dst_y = '0;
  logic [3:0]  gap_cfg = '0;
  logic        gap_rand = 1'b0;
  logic        GntDnStr = 1'b0, DnStrFull = 1'b0;
  logic        ReqDnStr, done;
  logic [35:0] PacketOut;
`ifdef INJ_STATS_EN
  logic [31:0] sent_cnt, stall_cnt;
`endif

  noc_traffic_injector #(
    .DATA_WIDTH(36), .DIM(4), .PKT_ID_W(10), .MOD_ID_W(6), .MODULE_ID(6'h2A),
    .X_SRC(4'h2), .Y_SRC(4'h5), .GAP_W(4), .MAX_PACKETS(MAXP), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .mode(mode),
    .cfg_dst_x(cfg_dst_x), .cfg_dst_y(cfg_dst_y),
    .gap_cfg(gap_cfg), .gap_rand(gap_rand),
    .ReqDnStr(ReqDnStr), .GntDnStr(GntDnStr), .DnStrFull(DnStrFull),
    .PacketOut(PacketOut),
`ifdef INJ_STATS_EN
    .sent_cnt(sent_cnt), .stall_cnt(stall_cnt),
`endif
    .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference LFSR, straight from the polynomial definition
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  logic [15:0] lfsr_m, lfsr_prev;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      lfsr_m    <= 16'hACE1;
      lfsr_prev <= 16'hACE1;
    end else begin
      lfsr_prev <= lfsr_m;
      lfsr_m    <= lfsr_step(lfsr_m);
    end
  end

  function automatic logic [35:0] hdr(input logic [3:0] dx, input logic [3:0] dy, input logic [9:0] id);
    return {dx, dy, 4'h2, 4'h5, id, 6'h2A, 4'h0};
  endfunction

  typedef struct {
    logic [1:0] mode;
    logic [3:0] dx;
    logic [3:0] dy;
    logic [9:0] id;
  } exp_t;

  exp_t       q[$];
  logic [9:0] exp_id = '0;

  task automatic push_exp();
    exp_t e;
    exp_id = exp_id + 1'b1;
    e.mode = mode; e.dx = cfg_dst_x; e.dy = cfg_dst_y; e.id = exp_id;
    q.push_back(e);
  endtask

  // monitor: each new request must carry the next expected packet; held requests stay stable
  logic        req_prev = 1'b0;
  logic [35:0] pkt_prev = '0;
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] dx, dy;
    if (reset) begin
      req_prev = 1'b0;
    end else begin
      if (ReqDnStr && !req_prev) begin
        chk("queue_nonempty", 64'(q.size() != 0), 64'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          case (e.mode)
            2'd0: begin dx = e.dx; dy = e.dy; end
            2'd1: begin
              dx = lfsr_prev[7:4]; dy = lfsr_prev[3:0];
              if (dx == 4'h2 && dy == 4'h5) dx = 4'h3;
            end
            2'd2: begin dx = 4'h5; dy = 4'h2; end
            default: begin dx = 4'hD; dy = 4'hA; end
          endcase
          chk($sformatf("packet_id%0d_mode%0d", e.id, e.mode), 64'(PacketOut), 64'(hdr(dx, dy, e.id)));
        end
      end else if (ReqDnStr && req_prev) begin
        chk("packet_hold", 64'(PacketOut), 64'(pkt_prev));
      end
      req_prev = ReqDnStr;
      pkt_prev = PacketOut;
    end
  end

  task automatic wait_rise(output int c);
    c = 0;
    while (ReqDnStr && c < 200) begin @(negedge clk); c++; end
    while (!ReqDnStr && c < 200) begin @(negedge clk); c++; end
    if (c >= 200) chk("req_timeout", 64'(ReqDnStr), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, seen;
    bit granted, r;
    repeat (3) @(negedge clk);
    chk("reset_req", 64'(ReqDnStr), 64'd0);
    chk("reset_pkt", 64'(PacketOut), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b0;

    // fixed destination, zero gap, grant held: rise on edge 3, then every 4 cycles
    mode = 2'd0; cfg_dst_x = 4'b1001; cfg_dst_y = 4'b1100;
    gap_cfg = '0; gap_rand = 1'b0; GntDnStr = 1'b1; DnStrFull = 1'b0; en = 1'b1;
    push_exp();
    wait_rise(c);
    chk("first_latency", 64'(c), 64'd3);
    push_exp();
    wait_rise(c);
    chk("period_min", 64'(c), 64'd4);
    en = 1'b0;
    repeat (2) @(negedge clk);

    // backpressure held for 10 cycles in SEND (transpose pattern)
    mode = 2'd2; DnStrFull = 1'b1; en = 1'b1;
    push_exp();
    repeat (2) @(negedge clk);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (ReqDnStr) seen++;
      @(negedge clk);
    end
    chk("req_during_full", 64'(seen), 64'd0);
    DnStrFull = 1'b0;
    @(negedge clk);
    chk("req_after_release", 64'(ReqDnStr), 64'd1);
`ifdef INJ_STATS_EN
    chk("stall_cnt", 64'(stall_cnt), 64'd10);
    chk("sent_cnt_2", 64'(sent_cnt), 64'd2);
`endif

    // gap 5 -> 9 cycles between rises (bit-complement pattern)
    gap_cfg = 4'd5; mode = 2'd3;
    push_exp();
    wait_rise(c);
    chk("gap5_period", 64'(c), 64'd9);

    // drop en while in WAIT: grant completes, nothing further
    en = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ReqDnStr) seen++;
    end
    chk("no_req_en_low", 64'(seen), 64'd0);
    mode = 2'd0; cfg_dst_x = 4'h7; cfg_dst_y = 4'h3; gap_cfg = 4'd1; GntDnStr = 1'b0; en = 1'b1;
    push_exp();
    wait_rise(c);
    chk("resume_req", 64'(ReqDnStr), 64'd1);

    // asynchronous reset in the middle of WAIT
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("midwait_req", 64'(ReqDnStr), 64'd0);
    chk("midwait_pkt", 64'(PacketOut), 64'd0);
    chk("midwait_done", 64'(done), 64'd0);
`ifdef INJ_STATS_EN
    chk("midwait_sent_cnt", 64'(sent_cnt), 64'd0);
`endif
    q.delete();
    exp_id = '0;
    @(negedge clk);
    reset = 1'b0;
    mode = 2'd0; cfg_dst_x = 4'hE; cfg_dst_y = 4'h1; gap_cfg = '0; GntDnStr = 1'b1;
    push_exp();
    wait_rise(c);
    chk("post_reset_req", 64'(ReqDnStr), 64'd1);
    @(negedge clk);

    // randomized traffic up to the packet budget
    for (int k = 2; k <= int'(MAXP); k++) begin
      mode      = ($urandom_range(0, 1) == 1) ? 2'd1 : 2'($urandom_range(0, 3));
      cfg_dst_x = 4'($urandom);
      cfg_dst_y = 4'($urandom);
      gap_rand  = 1'($urandom_range(0, 1));
      gap_cfg   = 4'($urandom_range(0, 3));
      push_exp();
      granted = 1'b0;
      for (int n = 0; n < 300 && !granted; n++) begin
        r = ReqDnStr;
        GntDnStr  = 1'($urandom_range(0, 1));
        DnStrFull = ($urandom_range(0, 3) == 0);
        @(posedge clk);
        if (r && GntDnStr) granted = 1'b1;
        else @(negedge clk);
      end
      if (!granted) chk("grant_timeout", 64'(granted), 64'd1);
      @(negedge clk);
      chk($sformatf("done_after_%0d", k), 64'(done), 64'(k == int'(MAXP)));
    end

    seen = 0;
    for (int i = 0; i < 100; i++) begin
      GntDnStr = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (ReqDnStr) seen++;
    end
    chk("no_req_after_budget", 64'(seen), 64'd0);
    chk("done_sticky", 64'(done), 64'd1);
`ifdef INJ_STATS_EN
    chk("sent_cnt_budget", 64'(sent_cnt), 64'(MAXP));
`endif
    chk("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
